// File: rtl/clk_train_pkg.sv
// Shared definitions for the forwarded-clock training pattern.
// Used by the TX clock gate generator and the RX pattern checker.
package clk_train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACT = 2'd1,
        ST_TRACK    = 2'd2,
        ST_DONE     = 2'd3
    } chk_state_e;

    localparam int DEF_EXP_ITER   = 128;
    localparam int DEF_PASS_MIN   = 112;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_END_IDLE   = 4;
    // One 1,1,0 group carries two pattern iterations.
    localparam int ITER_PER_GROUP = 2;

    localparam logic [2:0] RUN_SAT = 3'd7;

    function automatic logic [7:0] add_group_iters(input logic [7:0] count);
        logic [8:0] sum;
        sum = {1'b0, count} + 9'(ITER_PER_GROUP);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [2:0] run_inc(input logic [2:0] run);
        return (run == RUN_SAT) ? RUN_SAT : run + 3'd1;
    endfunction

endpackage

// File: rtl/clk_run_length_tracker.sv
// Measures active/idle run lengths of the forwarded-clock activity flag and
// flags group boundaries (idle->active edge) and the end-of-pattern idle stretch.
module clk_run_length_tracker
    import clk_train_pkg::*;
#(
    parameter int END_IDLE = DEF_END_IDLE
)(
    input  logic i_dig_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_arm,
    input  logic i_track,
    input  logic i_rx_clk_active,
    output logic o_group_close,
    output logic o_group_good,
    output logic o_end_of_pattern
);

    localparam logic [2:0] END_IDLE_M1 = 3'(END_IDLE - 1);

    logic [2:0] act_run_r;
    logic [2:0] idle_run_r;
    logic       act_ok_s;
    logic       idle_ok_s;

    assign act_ok_s  = (act_run_r == 3'd1) || (act_run_r == 3'd2);
    assign idle_ok_s = (idle_run_r == 3'd1) || (idle_run_r == 3'd2);

    // Run-length counters; arming seeds the first burst with the activating cycle.
    always_ff @(posedge i_dig_clk) begin
        if (i_rst || i_clear) begin
            act_run_r  <= 3'd0;
            idle_run_r <= 3'd0;
        end else if (i_arm) begin
            act_run_r  <= 3'd1;
            idle_run_r <= 3'd0;
        end else if (i_track) begin
            if (i_rx_clk_active) begin
                if (idle_run_r != 3'd0) begin
                    act_run_r  <= 3'd1;
                    idle_run_r <= 3'd0;
                end else begin
                    act_run_r  <= run_inc(act_run_r);
                end
            end else begin
                idle_run_r <= run_inc(idle_run_r);
            end
        end
    end

    // Group boundary decode; the final group has no trailing edge so only its burst is judged.
    always_comb begin
        o_group_close    = 1'b0;
        o_end_of_pattern = 1'b0;
        o_group_good     = 1'b0;
        if (i_track && i_rx_clk_active && (idle_run_r != 3'd0)) begin
            o_group_close = 1'b1;
            o_group_good  = act_ok_s && idle_ok_s;
        end else if (i_track && !i_rx_clk_active && (idle_run_r == END_IDLE_M1)) begin
            o_end_of_pattern = 1'b1;
            o_group_good     = act_ok_s;
        end else begin
            o_group_good = 1'b0;
        end
    end

endmodule

// File: rtl/clock_pattern_checker.sv
// RX-side checker for the forwarded-clock training pattern: counts good
// 1,1,0 groups and reports done/pass back to the LTSM.
module clock_pattern_checker
    import clk_train_pkg::*;
#(
    parameter int EXP_ITER = DEF_EXP_ITER,
    parameter int PASS_MIN = DEF_PASS_MIN,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int END_IDLE = DEF_END_IDLE
)(
    input  logic       i_dig_clk,
    input  logic       i_rst,
    input  logic       i_start_check,
    input  logic       i_ltsm_in_reset,
    input  logic       i_rx_clk_active,
    output logic       o_busy,
    output logic       o_check_done,
    output logic       o_check_pass,
    output logic [7:0] o_good_count
);

    localparam logic [7:0] GROUP_LAST   = 8'(EXP_ITER / ITER_PER_GROUP - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [8:0] PASS_MIN_W   = 9'(PASS_MIN);

    chk_state_e state_r;
    logic [7:0] timeout_cnt_r;
    logic [7:0] group_cnt_r;
    logic [7:0] good_count_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;

    logic       clear_s;
    logic       arm_s;
    logic       track_s;
    logic       group_close_s;
    logic       group_good_s;
    logic       end_of_pattern_s;
    logic [7:0] good_next_s;

    assign clear_s     = i_ltsm_in_reset || (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign arm_s       = (state_r == ST_WAIT_ACT) && i_rx_clk_active;
    assign track_s     = (state_r == ST_TRACK);
    assign good_next_s = group_good_s ? add_group_iters(good_count_r) : good_count_r;

    clk_run_length_tracker #(
        .END_IDLE (END_IDLE)
    ) u_run_tracker (
        .i_dig_clk        (i_dig_clk),
        .i_rst            (i_rst),
        .i_clear          (clear_s),
        .i_arm            (arm_s),
        .i_track          (track_s),
        .i_rx_clk_active  (i_rx_clk_active),
        .o_group_close    (group_close_s),
        .o_group_good     (group_good_s),
        .o_end_of_pattern (end_of_pattern_s)
    );

    // Checker FSM with counters and registered result flags; LTSM reset outranks start.
    always_ff @(posedge i_dig_clk) begin
        if (i_rst || i_ltsm_in_reset) begin
            state_r       <= ST_IDLE;
            timeout_cnt_r <= 8'd0;
            group_cnt_r   <= 8'd0;
            good_count_r  <= 8'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (i_start_check) begin
                        state_r       <= ST_WAIT_ACT;
                        timeout_cnt_r <= 8'd0;
                        group_cnt_r   <= 8'd0;
                        good_count_r  <= 8'd0;
                        busy_r        <= 1'b1;
                        done_r        <= 1'b0;
                        pass_r        <= 1'b0;
                    end
                end
                ST_WAIT_ACT: begin
                    if (i_rx_clk_active) begin
                        state_r <= ST_TRACK;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
                        if (timeout_cnt_r == TIMEOUT_LAST) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= 1'b0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (group_close_s || end_of_pattern_s) begin
                        group_cnt_r  <= group_cnt_r + 8'd1;
                        good_count_r <= good_next_s;
                        // The burst that closes the last expected group is never evaluated.
                        if (end_of_pattern_s || (group_cnt_r == GROUP_LAST)) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= ({1'b0, good_next_s} >= PASS_MIN_W);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = busy_r;
    assign o_check_done = done_r;
    assign o_check_pass = pass_r;
    assign o_good_count = good_count_r;

endmodule

// File: tb/tb_clock_pattern_checker.sv
// Bench for clock_pattern_checker: a run-length model of the received stream
// is compared every cycle, plus hand-computed literal expectations per scenario.
module tb_clock_pattern_checker;

    localparam int EXP_ITER = 128;
    localparam int PASS_MIN = 112;
    localparam int TIMEOUT  = 255;
    localparam int END_IDLE = 4;
    localparam int GROUPS   = EXP_ITER / 2;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic       start_check   = 1'b0;
    logic       ltsm_in_reset = 1'b0;
    logic       rx_clk_active = 1'b0;
    logic       busy;
    logic       check_done;
    logic       check_pass;
    logic [7:0] good_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: phase 0 idle, 1 armed, 2 done; history of activity since arming.
    int   m_phase = 0;
    bit   m_hist[$];
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;
    logic exp_pass = 1'b0;
    int   exp_good = 0;

    always #5 clk = ~clk;

    clock_pattern_checker #(
        .EXP_ITER (EXP_ITER),
        .PASS_MIN (PASS_MIN),
        .TIMEOUT  (TIMEOUT),
        .END_IDLE (END_IDLE)
    ) dut (
        .i_dig_clk       (clk),
        .i_rst           (rst),
        .i_start_check   (start_check),
        .i_ltsm_in_reset (ltsm_in_reset),
        .i_rx_clk_active (rx_clk_active),
        .o_busy          (busy),
        .o_check_done    (check_done),
        .o_check_pass    (check_pass),
        .o_good_count    (good_count)
    );

    // Decompose the history into active/idle runs and judge each group from them.
    function automatic void m_eval(output bit fin, output int good);
        int runs[$];
        int first;
        int closes;
        fin    = 1'b0;
        good   = 0;
        closes = 0;
        first  = -1;
        foreach (m_hist[k]) begin
            if (first < 0 && m_hist[k]) first = k;
        end
        if (first < 0) begin
            fin = (m_hist.size() >= TIMEOUT);
            return;
        end
        for (int k = first; k < m_hist.size(); k++) begin
            if (k == first) runs.push_back(1);
            else if (m_hist[k] != m_hist[k-1]) runs.push_back(1);
            else runs[runs.size()-1] = runs[runs.size()-1] + 1;
        end
        for (int p = 0; (p + 1 < runs.size()) && !fin; p += 2) begin
            int a;
            int i;
            a = runs[p];
            i = runs[p+1];
            if (p + 2 < runs.size()) begin
                closes++;
                if (a <= 2 && i <= 2) good++;
                if (closes == GROUPS) fin = 1'b1;
            end else if (i >= END_IDLE) begin
                closes++;
                if (a <= 2) good++;
                fin = 1'b1;
            end
        end
    endfunction

    task automatic model_update(input logic r, input logic st, input logic lr, input logic act);
        bit fin;
        int good;
        if (r || lr) begin
            m_phase = 0;
            m_hist.delete();
            exp_busy = 1'b0; exp_done = 1'b0; exp_pass = 1'b0; exp_good = 0;
        end else if (m_phase != 1) begin
            if (st) begin
                m_phase = 1;
                m_hist.delete();
                exp_busy = 1'b1; exp_done = 1'b0; exp_pass = 1'b0; exp_good = 0;
            end
        end else begin
            m_hist.push_back(act);
            m_eval(fin, good);
            exp_good = (2 * good > 255) ? 255 : 2 * good;
            if (fin) begin
                m_phase  = 2;
                exp_busy = 1'b0;
                exp_done = 1'b1;
                exp_pass = (exp_good >= PASS_MIN);
            end
        end
    endtask

    task automatic step(input logic r, input logic st, input logic lr, input logic act);
        @(negedge clk);
        rst = r; start_check = st; ltsm_in_reset = lr; rx_clk_active = act;
        @(posedge clk);
        model_update(r, st, lr, act);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic grp(input int a, input int i);
        repeat (a) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (i) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_chk();
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checks++;
                if (busy !== exp_busy || check_done !== exp_done ||
                    check_pass !== exp_pass || good_count !== 8'(exp_good)) begin
                    failures++;
                    $display("FAIL cycle_model t=%0t busy/done/pass/good actual=%b/%b/%b/%0d expected=%b/%b/%b/%0d",
                             $time, busy, check_done, check_pass, good_count,
                             exp_busy, exp_done, exp_pass, exp_good);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_done;
        first_done = -1;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        #1;
        check_lit("reset_busy", 32'(busy), 32'd0);
        check_lit("reset_done", 32'(check_done), 32'd0);
        check_lit("reset_pass", 32'(check_pass), 32'd0);
        check_lit("reset_good", 32'(good_count), 32'd0);

        // Ideal pattern: done on the 4th trailing idle cycle
        start_chk();
        idle(2);
        repeat (64) grp(2, 1);
        idle(2);
        #1;
        check_lit("ideal_not_done_yet", 32'(check_done), 32'd0);
        idle(1);
        #1;
        check_lit("ideal_done", 32'(check_done), 32'd1);
        check_lit("ideal_pass", 32'(check_pass), 32'd1);
        check_lit("ideal_good", 32'(good_count), 32'd128);
        idle(3);

        // Re-arm from DONE, then a second ideal run
        start_chk();
        #1;
        check_lit("rearm_done_clear", 32'(check_done), 32'd0);
        check_lit("rearm_good_clear", 32'(good_count), 32'd0);
        check_lit("rearm_busy", 32'(busy), 32'd1);
        idle(1);
        repeat (64) grp(2, 1);
        idle(6);
        #1;
        check_lit("rearm2_pass", 32'(check_pass), 32'd1);
        check_lit("rearm2_good", 32'(good_count), 32'd128);

        // No activity: timeout exactly 255 cycles after WAIT_ACT entry
        start_chk();
        for (int k = 1; k <= 300; k++) begin
            idle(1);
            #1;
            if (check_done && first_done < 0) first_done = k;
        end
        check_lit("timeout_latency", 32'(first_done), 32'd255);
        check_lit("timeout_pass", 32'(check_pass), 32'd0);
        check_lit("timeout_good", 32'(good_count), 32'd0);

        // Ten groups with a 3-cycle burst are not counted
        start_chk();
        idle(1);
        for (int g = 0; g < 64; g++) begin
            grp(((g % 6 == 3) && (g < 60)) ? 3 : 2, 1);
        end
        idle(6);
        #1;
        check_lit("corrupt_done", 32'(check_done), 32'd1);
        check_lit("corrupt_good", 32'(good_count), 32'd108);
        check_lit("corrupt_pass", 32'(check_pass), 32'd0);

        // Early stop after 40 groups
        start_chk();
        repeat (40) grp(2, 1);
        idle(2);
        #1;
        check_lit("early_not_done_yet", 32'(check_done), 32'd0);
        idle(1);
        #1;
        check_lit("early_done", 32'(check_done), 32'd1);
        check_lit("early_good", 32'(good_count), 32'd80);
        check_lit("early_pass", 32'(check_pass), 32'd0);
        idle(2);

        // Group limit: the 64th edge close ends the check while the pattern continues
        start_chk();
        repeat (64) grp(2, 1);
        #1;
        check_lit("limit_not_done_yet", 32'(check_done), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check_lit("limit_done", 32'(check_done), 32'd1);
        check_lit("limit_good", 32'(good_count), 32'd128);
        check_lit("limit_pass", 32'(check_pass), 32'd1);
        grp(1, 1);
        grp(2, 6);

        // Mixed run lengths: six good groups including the final one
        start_chk();
        grp(1, 1); grp(2, 2); grp(1, 3); grp(3, 1); grp(2, 1);
        grp(1, 2); grp(4, 2); grp(2, 3); grp(1, 1); grp(2, 4);
        #1;
        check_lit("mixed_done", 32'(check_done), 32'd1);
        check_lit("mixed_good", 32'(good_count), 32'd12);
        check_lit("mixed_pass", 32'(check_pass), 32'd0);

        // Abort mid-TRACK together with a start pulse
        start_chk();
        repeat (5) grp(2, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        check_lit("abort_busy", 32'(busy), 32'd0);
        check_lit("abort_done", 32'(check_done), 32'd0);
        check_lit("abort_pass", 32'(check_pass), 32'd0);
        check_lit("abort_good", 32'(good_count), 32'd0);
        idle(3);
        #1;
        check_lit("abort_stays_idle", 32'(busy), 32'd0);

        // Synchronous reset mid-operation
        start_chk();
        repeat (5) grp(2, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check_lit("midrst_busy", 32'(busy), 32'd0);
        check_lit("midrst_good", 32'(good_count), 32'd0);
        idle(2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
